huff_seq_ctrl: RTL
==================

Name: huff_seq_ctrl

Overview:
- Top-level phase sequencer for the Huffman encode pipeline.
- Consumes the slave-side bus events (start, file-size write, data-word capture, stop) and the completion handshakes of the byte counter, tree builder, code emitter and output flush stage.
- Tracks the bytes remaining in the file and issues single-cycle go pulses to each stage in order.
- Reports busy, done or a coded error to the host.

Parameters:
WDOG_CYCLES, 1024, watchdog limit in HCLK cycles per wait phase (only used when HUFF_SEQ_WDOG_EN is defined)
WDOG_W, 11, width of the watchdog counter; must satisfy 2^WDOG_W > WDOG_CYCLES

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: host start command
size_wr  in  1  one-cycle pulse: file_size is valid this cycle
file_size  in  16  file length in bytes
word_strobe  in  1  one-cycle pulse: a 32-bit data word was captured
stop  in  1  one-cycle pulse: host end-of-file command
cnt_done  in  1  counter has finished processing the current word
build_done  in  1  tree build complete (level)
code_done  in  1  code emission complete (level)
flush_done  in  1  output flush complete (level)
ack  in  1  host acknowledge; clears done/err
cnt_go  out  1  one-cycle pulse: counter, process captured word
build_go  out  1  one-cycle pulse: start tree build
code_go  out  1  one-cycle pulse: start code emission
flush_go  out  1  one-cycle pulse: start flush
busy  out  1  high in states ARM..FLUSH
done  out  1  high in DONE
err  out  1  high in ERR
err_code  out  3  0 none, 1 empty file, 2 overrun, 3 short file, 4 timeout
bytes_left  out  16  bytes still expected
state_o  out  3  current state encoding

Behaviour:
- Reset (HRESETn asynchronous, active-low; clock HCLK): state IDLE; all outputs 0; internal cnt_busy=0; stop_seen=0.
- State encodings: IDLE=0, ARM=1, COUNT=2, BUILD=3, CODE=4, FLUSH=5, DONE=6, ERR=7. All outputs are registered.
- IDLE:
  - start -> ARM.
  - All other inputs, including ack, are ignored.
- ARM:
  - size_wr with file_size==0 -> ERR, code 1.
  - size_wr with file_size!=0 -> latch bytes_left=file_size, go to COUNT.
  - stop or word_strobe before size_wr -> ERR, code 3.
- COUNT, word handling:
  - word_strobe with cnt_busy=0 and bytes_left>0: cnt_go=1 next cycle; bytes_left -= min(4, bytes_left) (a final partial word may be 1-3 bytes); cnt_busy=1.
  - cnt_busy clears on cnt_done.
  - word_strobe while cnt_busy=1 -> ERR, code 2.
  - word_strobe with bytes_left==0 -> ERR, code 2.
- COUNT, stop handling:
  - stop with bytes_left!=0 (after any same-cycle word update) -> ERR, code 3.
  - stop with bytes_left==0 and cnt_busy=0 -> BUILD.
  - stop with bytes_left==0 and cnt_busy=1 -> set stop_seen; go to BUILD on the cycle after cnt_done.
- Same-cycle word_strobe and stop: the word is accounted first, then stop is evaluated against the updated bytes_left.
- BUILD: build_go=1 for exactly the first cycle in the state; build_done -> CODE.
- CODE: code_go=1 on the first cycle; code_done -> FLUSH.
- FLUSH: flush_go=1 on the first cycle; flush_done -> DONE.
- A done level that is already high on the entry cycle is ignored; it is only sampled from the second cycle onward.
- DONE: done=1, bytes_left=0; ack -> IDLE.
- ERR: err=1 and err_code held; ack -> IDLE, which clears err_code to 0 and bytes_left to 0.
- Command conflicts:
  - start in any non-IDLE state is ignored.
  - ack is ignored outside DONE/ERR.
- Reset mid-operation: returns to IDLE immediately; any pending go pulse is cancelled.

Optional Feature:
- Macro: HUFF_SEQ_WDOG_EN.
- When defined: a watchdog counter clears on entry to BUILD, CODE and FLUSH, and on each cnt_go. It counts while waiting for the corresponding done signal. On reaching WDOG_CYCLES -> ERR, code 4.
- When not defined: no watchdog logic; the block waits indefinitely and err_code 4 is never produced.

Test Plan:
- start, size_wr(10), 3 word_strobes each followed by cnt_done, stop -> bytes_left 10->6->2->0; build_go, code_go, flush_go each pulse once; done=1; ack -> IDLE.
- start, size_wr(0) -> ERR with err_code=1; ack -> state_o=0, err_code=0.
- size_wr(4), word_strobe, then second word_strobe before cnt_done -> ERR, err_code=2.
- size_wr(8), one word, then stop -> bytes_left=4; ERR, err_code=3.
- size_wr(4), word_strobe, stop before cnt_done -> stays COUNT; cnt_done -> BUILD next cycle; start pulse during CODE ignored.
- With HUFF_SEQ_WDOG_EN and WDOG_CYCLES=16: build_done held low -> ERR, err_code=4 after 16 cycles. Without the macro: still in BUILD after 1000 cycles.

Source files
------------

// File: rtl/huff_seq_ctrl.sv
// huff_seq_ctrl: top-level phase sequencer for the Huffman encode pipeline.
// It tracks the bytes still expected in the file and steps through
// ARM -> COUNT -> BUILD -> CODE -> FLUSH -> DONE. Each stage gets a
// single-cycle go pulse. Protocol violations end in ERR with a code.
// Optional feature: define HUFF_SEQ_WDOG_EN to add a per-phase watchdog
// that raises err_code 4 after WDOG_CYCLES cycles spent waiting.
module huff_seq_ctrl #(
    parameter int WDOG_CYCLES = 1024,
    parameter int WDOG_W      = 11
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        size_wr,
    input  logic [15:0] file_size,
    input  logic        word_strobe,
    input  logic        stop,
    input  logic        cnt_done,
    input  logic        build_done,
    input  logic        code_done,
    input  logic        flush_done,
    input  logic        ack,
    output logic        cnt_go,
    output logic        build_go,
    output logic        code_go,
    output logic        flush_go,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] bytes_left,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_COUNT = 3'd2,
        S_BUILD = 3'd3,
        S_CODE  = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    localparam logic [2:0] E_EMPTY   = 3'd1;
    localparam logic [2:0] E_OVERRUN = 3'd2;
    localparam logic [2:0] E_SHORT   = 3'd3;
    localparam logic [2:0] E_TIMEOUT = 3'd4;

    // The watchdog counter must be able to hold WDOG_CYCLES-1.
    if (WDOG_CYCLES < 1 || (2 ** WDOG_W) <= WDOG_CYCLES) begin : g_bad_wdog_cfg
        $error("huff_seq_ctrl: WDOG_W too narrow for WDOG_CYCLES");
    end

    state_t      r_state;
    logic        r_cnt_go, r_build_go, r_code_go, r_flush_go;
    logic        r_busy, r_done, r_err;
    logic [2:0]  r_err_code;
    logic [15:0] r_bytes_left;
    logic        r_cnt_busy;
    logic        r_stop_seen;

    // Word accounting: a word is legal only with the counter idle and bytes
    // still expected. A final partial word consumes whatever is left (1-3).
    logic        w_word_ok;
    logic [15:0] w_bl_after_word;
    logic [15:0] w_bl_upd;
    logic        w_cnt_busy_upd;
    logic        w_wdog_exp;

    assign w_word_ok       = word_strobe && !r_cnt_busy && (r_bytes_left != 16'd0);
    assign w_bl_after_word = (r_bytes_left >= 16'd4) ? (r_bytes_left - 16'd4) : 16'd0;
    assign w_bl_upd        = w_word_ok ? w_bl_after_word : r_bytes_left;
    assign w_cnt_busy_upd  = w_word_ok || (r_cnt_busy && !cnt_done);

`ifdef HUFF_SEQ_WDOG_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              w_wdog_wait;
    logic              w_any_go;

    // A go pulse marks the first cycle of a wait; its value of r_wdog is stale
    // and masked, so the counter restarts at 1 for the second cycle.
    assign w_any_go    = r_cnt_go || r_build_go || r_code_go || r_flush_go;
    assign w_wdog_wait = (r_state inside {S_BUILD, S_CODE, S_FLUSH}) ||
                         (r_state == S_COUNT && r_cnt_busy);
    assign w_wdog_exp  = w_wdog_wait && !w_any_go &&
                         (r_wdog == WDOG_W'(WDOG_CYCLES - 1));

    // Watchdog: counts cycles spent waiting for the current done handshake.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wdog <= '0;
        end else if (w_any_go) begin
            r_wdog <= WDOG_W'(1);
        end else if (w_wdog_wait) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_wdog_exp = 1'b0;
`endif

    // Phase sequencer: state, go pulses, status and byte accounting.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_cnt_go     <= 1'b0;
            r_build_go   <= 1'b0;
            r_code_go    <= 1'b0;
            r_flush_go   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 3'd0;
            r_bytes_left <= 16'd0;
            r_cnt_busy   <= 1'b0;
            r_stop_seen  <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in the same
            // edge overrides them, so each go pulse lasts exactly one cycle.
            r_cnt_go   <= 1'b0;
            r_build_go <= 1'b0;
            r_code_go  <= 1'b0;
            r_flush_go <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_ARM;
                        r_busy      <= 1'b1;
                        r_cnt_busy  <= 1'b0;
                        r_stop_seen <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (size_wr) begin
                        if (file_size == 16'd0) begin
                            r_state <= S_ERR; r_busy <= 1'b0; r_err <= 1'b1; r_err_code <= E_EMPTY;
                        end else begin
                            r_bytes_left <= file_size;
                            r_state      <= S_COUNT;
                        end
                    end else if (stop || word_strobe) begin
                        r_state <= S_ERR; r_busy <= 1'b0; r_err <= 1'b1; r_err_code <= E_SHORT;
                    end
                end
                S_COUNT: begin
                    r_bytes_left <= w_bl_upd;
                    r_cnt_busy   <= w_cnt_busy_upd;
                    r_cnt_go     <= w_word_ok;
                    if (word_strobe && !w_word_ok) begin
                        r_state <= S_ERR; r_busy <= 1'b0; r_err <= 1'b1; r_err_code <= E_OVERRUN;
                    end else if (stop && !r_stop_seen) begin
                        // Stop is judged after this cycle's word has been counted.
                        if (w_bl_upd != 16'd0) begin
                            r_cnt_go <= 1'b0;
                            r_state  <= S_ERR; r_busy <= 1'b0; r_err <= 1'b1; r_err_code <= E_SHORT;
                        end else if (w_cnt_busy_upd) begin
                            r_stop_seen <= 1'b1;
                        end else begin
                            r_state    <= S_BUILD;
                            r_build_go <= 1'b1;
                        end
                    end else if (r_stop_seen && cnt_done) begin
                        r_state    <= S_BUILD;
                        r_build_go <= 1'b1;
                    end else if (w_wdog_exp && !cnt_done) begin
                        r_state <= S_ERR; r_busy <= 1'b0; r_err <= 1'b1; r_err_code <= E_TIMEOUT;
                    end
                end
                // A done level present on the entry cycle (go still high) is ignored.
                S_BUILD: begin
                    if (!r_build_go && build_done) begin
                        r_state   <= S_CODE;
                        r_code_go <= 1'b1;
                    end else if (w_wdog_exp) begin
                        r_state <= S_ERR; r_busy <= 1'b0; r_err <= 1'b1; r_err_code <= E_TIMEOUT;
                    end
                end
                S_CODE: begin
                    if (!r_code_go && code_done) begin
                        r_state    <= S_FLUSH;
                        r_flush_go <= 1'b1;
                    end else if (w_wdog_exp) begin
                        r_state <= S_ERR; r_busy <= 1'b0; r_err <= 1'b1; r_err_code <= E_TIMEOUT;
                    end
                end
                S_FLUSH: begin
                    if (!r_flush_go && flush_done) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_bytes_left <= 16'd0;
                    end else if (w_wdog_exp) begin
                        r_state <= S_ERR; r_busy <= 1'b0; r_err <= 1'b1; r_err_code <= E_TIMEOUT;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (ack) begin
                        r_state      <= S_IDLE;
                        r_err        <= 1'b0;
                        r_err_code   <= 3'd0;
                        r_bytes_left <= 16'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cnt_go     = r_cnt_go;
    assign build_go   = r_build_go;
    assign code_go    = r_code_go;
    assign flush_go   = r_flush_go;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign bytes_left = r_bytes_left;
    assign state_o    = r_state;

endmodule
